reg_write_arbiter: RTL and testbench
====================================

# reg_write_arbiter

Round-robin write arbiter that shares a bank of enable-gated storage registers among several requesters. Each requester presents an address and a data word with a request. The block grants one requester at a time, drives a one-hot write enable and the shared data bus into the register bank, then returns a one-cycle acknowledge. It sits between the requesting control logic and the register bank, and is the only source of the bank's `en` and `din` inputs.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `NREG`, default 8: number of registers in the bank, 2..16.
- `DW`, default 8: data width of each register.
- `AW`, default `$clog2(NREG)`: address width. Derived; never overridden.
- `clk`, input, 1: the only clock. All state changes on its rising edge.
- `rst`, input, 1: asynchronous reset, active-high.
- `req`, input, NREQ: per-requester write request.
  - Level signal; held until the matching `gnt` bit is seen.
- `addr`, input, NREQ*AW: per-requester register address.
  - Requester i occupies bits [i*AW +: AW].
  - Must be stable while `req[i]` is high.
- `wdata`, input, NREQ*DW: per-requester write data.
  - Requester i occupies bits [i*DW +: DW].
  - Must be stable while `req[i]` is high.
- `gnt`, output, NREQ: one-hot, one-cycle acknowledge; the write has completed.
- `err`, output, 1: one-cycle pulse, coincident with `gnt`, when the granted address is >= NREG.
- `reg_en`, output, NREG: one-hot write enable to the register bank.
- `reg_din`, output, DW: shared write data to the register bank.
- `busy`, output, 1: high whenever the state machine is not in IDLE.

## Operation
- State machine states: IDLE, WRITE, ACK.
- **IDLE**
  - If any `req` bit is high, pick a winner by round-robin, starting the search at pointer `ptr`.
  - Latch the winner index, its address and its data.
  - Go to WRITE.
  - If no request is high, stay in IDLE.
- **WRITE** (lasts one cycle)
  - `reg_en[addr_latched]` = 1 and `reg_din` = latched data.
  - The register captures the data at the end of this cycle.
  - If the latched address is >= NREG, `reg_en` stays all-zero and the error flag is latched.
  - Go to ACK.
- **ACK** (lasts one cycle)
  - `gnt[winner]` = 1, and `err` = 1 if the error flag is set.
  - `ptr` ← (winner + 1) mod NREQ.
  - Go to IDLE.
- Requester obligation: drop `req[i]` on the edge that ends the ACK cycle. It may reassert it one cycle later at the earliest.
  - The arbiter therefore never re-grants a stale request.
- Round-robin fairness: a continuously requesting requester waits at most NREQ-1 other grants.
- `ptr` reset value is 0, so at a reset tie requester 0 wins.
- `req` bits that rise during WRITE or ACK are ignored until the next IDLE evaluation.
- `reg_en`, `reg_din`, `gnt`, `err` and `busy` are all registered outputs.
  - `reg_din` holds its last value outside WRITE.
  - `reg_en`, `gnt` and `err` are zero outside their state.
- Reset values:
  - State IDLE, `ptr` = 0.
  - `gnt`, `err`, `reg_en`, `busy` = 0; `reg_din` = 0.
  - Latched index, address and data = 0.
- Reset mid-operation takes effect immediately and asynchronously:
  - The write in progress is aborted: `reg_en` drops in the same cycle.
  - No `gnt` is issued for it.
  - The requester must re-request after reset.

## Timing
- Request latency, with `req[i]` first high in cycle n while the block is IDLE and `i` wins:
  - `reg_en` and `reg_din` are valid in cycle n+1.
  - The register holds the new value from cycle n+2.
  - `gnt[i]` is high in cycle n+2.
  - The block is back in IDLE in cycle n+3.
- Throughput: one write per 3 cycles under continuous load.
- `busy` is high in cycles n+1 and n+2.
- Back-to-back writes by different requesters: the second `reg_en` pulse is exactly 3 cycles after the first.
- No combinational path from any input to any output.

## Structure
- Shared package `reg_arb_pkg`:
  - State enum `arb_state_t` (IDLE, WRITE, ACK).
  - Default parameter constants `ARB_NREQ`, `ARB_NREG`, `ARB_DW`.
- One sub-module, `rr_pick`: purely combinational round-robin picker.
  - Inputs: `req` vector and `ptr`.
  - Outputs: winner index and `any` flag.
  - Instantiated once.

## Test plan
- **Reset state:** assert `rst` -> all outputs 0, `busy` = 0.
  - Release, then `req` = 4'b0001, addr0 = 3, wdata0 = 8'hA5 -> `reg_en` = 8'b0000_1000 with `reg_din` = 8'hA5 at n+1; `gnt` = 4'b0001 at n+2.
- **Simultaneous requests:** `req` = 4'b1111, each requester writes a distinct address and data.
  - Grants come in order 0, 1, 2, 3, spaced 3 cycles apart.
  - Each `reg_en` matches its requester's address and data.
- **Fairness under continuous load:** requesters 0 and 2 request continuously.
  - Grants alternate 0, 2, 0, 2.
  - `ptr` wraps from 3 to 0 correctly.
- **Bad address:** with NREG = 6, requester 1 requests addr = 7.
  - `reg_en` stays all-zero in WRITE.
  - `gnt` = 4'b0010 and `err` = 1 together in ACK.
- **Reset mid-operation:** assert `rst` during WRITE.
  - `reg_en` = 0 in the same cycle, no `gnt`, state IDLE, `ptr` = 0.
  - After release, a held request is serviced afresh.
- **Late request:** `req[3]` rises during ACK of requester 0's grant.
  - It is not considered until the following IDLE.
  - It is then granted with 3-cycle latency from that IDLE cycle.

Source files
------------

// File: rtl/reg_arb_pkg.sv
// rtl/reg_arb_pkg.sv - shared types and default sizes for the register write arbiter
//
// Purpose: state encoding for the arbiter FSM and the default parameter
// values used by reg_write_arbiter.
package reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } arb_state_t;

  localparam int ARB_NREQ = 4;
  localparam int ARB_NREG = 8;
  localparam int ARB_DW   = 8;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
//
// Purpose: returns the first set bit of req, searching upward from ptr and
// wrapping at NREQ.
// Ports:
//   req    - request vector (NREQ bits)
//   ptr    - search start index, must be < NREQ
//   winner - index of the selected requester (0 when any is low)
//   any    - at least one request is set
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   winner,
  output logic            any
);

  // One extra bit so ptr + k never overflows before the wrap correction.
  localparam int CW = IW + 1;

  always_comb begin
    logic [CW-1:0] cand;
    cand   = '0;
    winner = '0;
    any    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + CW'(k);
      if (cand >= CW'(NREQ)) begin
        cand = cand - CW'(NREQ);
      end
      if (!any && req[cand[IW-1:0]]) begin
        any    = 1'b1;
        winner = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin write arbiter in front of a register bank
//
// Purpose: grants one requester at a time, drives a one-hot write enable and
// the shared data bus for one cycle, then acknowledges with a one-cycle gnt.
// Ports:
//   clk, rst - clock, asynchronous active-high reset
//   req      - per-requester level request
//   addr     - per-requester address, requester i at [i*AW +: AW]
//   wdata    - per-requester data, requester i at [i*DW +: DW]
//   gnt      - one-hot, one-cycle write acknowledge
//   err      - pulses with gnt when the granted address is out of range
//   reg_en   - one-hot register write enable (WRITE cycle only)
//   reg_din  - shared register write data, holds outside WRITE
//   busy     - FSM is not in IDLE
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NREQ = ARB_NREQ,
  parameter int NREG = ARB_NREG,
  parameter int DW   = ARB_DW,
  parameter int AW   = $clog2(NREG)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    gnt,
  output logic               err,
  output logic [NREG-1:0]    reg_en,
  output logic [DW-1:0]      reg_din,
  output logic               busy
);

  localparam int IW  = $clog2(NREQ);
  localparam int AXW = AW + 1;

  arb_state_t      state, state_nxt;
  logic [IW-1:0]   ptr, ptr_nxt;
  logic [IW-1:0]   win_q, win_nxt;
  logic [AW-1:0]   addr_q, addr_nxt;
  logic [DW-1:0]   data_q, data_nxt;

  logic [NREQ-1:0] gnt_nxt;
  logic            err_nxt;
  logic [NREG-1:0] reg_en_nxt;
  logic [DW-1:0]   reg_din_nxt;
  logic            busy_nxt;

  logic [IW-1:0]   pick;
  logic            any;
  logic [AW-1:0]   pick_addr;
  logic [DW-1:0]   pick_data;
  logic            addr_q_ok;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (pick),
    .any    (any)
  );

  // Select the candidate winner's address and data from the flat buses.
  always_comb begin
    pick_addr = '0;
    pick_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick == IW'(i)) begin
        pick_addr = addr[i*AW +: AW];
        pick_data = wdata[i*DW +: DW];
      end
    end
  end

  // Widened compare so it stays meaningful when NREG is a power of two.
  assign addr_q_ok = ({1'b0, addr_q} < AXW'(NREG));

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    win_nxt     = win_q;
    addr_nxt    = addr_q;
    data_nxt    = data_q;
    gnt_nxt     = '0;
    err_nxt     = 1'b0;
    reg_en_nxt  = '0;
    reg_din_nxt = reg_din;

    case (state)
      IDLE: begin
        if (any) begin
          win_nxt     = pick;
          addr_nxt    = pick_addr;
          data_nxt    = pick_data;
          reg_din_nxt = pick_data;
          // Out-of-range addresses match no bit, leaving reg_en all zero.
          for (int j = 0; j < NREG; j++) begin
            reg_en_nxt[j] = (pick_addr == AW'(j));
          end
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        for (int i = 0; i < NREQ; i++) begin
          gnt_nxt[i] = (win_q == IW'(i));
        end
        err_nxt   = ~addr_q_ok;
        state_nxt = ACK;
      end
      ACK: begin
        ptr_nxt   = (win_q == IW'(NREQ - 1)) ? '0 : win_q + IW'(1);
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      win_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      gnt     <= '0;
      err     <= 1'b0;
      reg_en  <= '0;
      reg_din <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      win_q   <= win_nxt;
      addr_q  <= addr_nxt;
      data_q  <= data_nxt;
      gnt     <= gnt_nxt;
      err     <= err_nxt;
      reg_en  <= reg_en_nxt;
      reg_din <= reg_din_nxt;
      busy    <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - directed table-driven bench for reg_write_arbiter
module tb_reg_write_arbiter;

  logic        clk;
  logic        rst;

  logic [3:0]  req;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic        err;
  logic [7:0]  reg_en;
  logic [7:0]  reg_din;
  logic        busy;

  logic [3:0]  req2;
  logic [11:0] addr2;
  logic [31:0] wdata2;
  logic [3:0]  gnt2;
  logic        err2;
  logic [5:0]  reg_en2;
  logic [7:0]  reg_din2;
  logic        busy2;

  int checks = 0;
  int errors = 0;

  reg_write_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .addr    (addr),
    .wdata   (wdata),
    .gnt     (gnt),
    .err     (err),
    .reg_en  (reg_en),
    .reg_din (reg_din),
    .busy    (busy)
  );

  reg_write_arbiter #(.NREQ(4), .NREG(6), .DW(8)) dut6 (
    .clk     (clk),
    .rst     (rst),
    .req     (req2),
    .addr    (addr2),
    .wdata   (wdata2),
    .gnt     (gnt2),
    .err     (err2),
    .reg_en  (reg_en2),
    .reg_din (reg_din2),
    .busy    (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [7:0]  en;
    logic [7:0]  din;
    logic [3:0]  gnt;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [3:0] q, input logic [11:0] a,
                              input logic [31:0] d, input logic [7:0] en, input logic [7:0] din,
                              input logic [3:0] g, input logic b);
    vec_t v;
    v.rst = r; v.req = q; v.addr = a; v.wdata = d;
    v.en = en; v.din = din; v.gnt = g; v.busy = b;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  initial begin
    logic [11:0] ad1, ad2, ad3, ad4;
    logic [31:0] wd1, wd2, wd3, wd4;
    int          bad_addrs[3];
    int          a;
    logic [5:0]  exp_en;
    logic        exp_err;

    ad1 = {3'd0, 3'd0, 3'd0, 3'd3}; wd1 = 32'h0000_00A5;
    ad2 = {3'd6, 3'd4, 3'd2, 3'd1}; wd2 = 32'h4433_2211;
    ad3 = {3'd0, 3'd3, 3'd0, 3'd5}; wd3 = 32'h00C3_005A;
    ad4 = {3'd1, 3'd3, 3'd5, 3'd2}; wd4 = 32'h99C3_E177;

    // single write after reset
    vecs.push_back(mk(0, 4'b0001, ad1, wd1, 8'h00, 8'h00, 4'h0, 0));
    vecs.push_back(mk(0, 4'b0001, ad1, wd1, 8'h08, 8'hA5, 4'h0, 1));
    vecs.push_back(mk(0, 4'b0000, ad1, wd1, 8'h00, 8'hA5, 4'h1, 1));
    vecs.push_back(mk(1, 4'b0000, ad1, wd1, 8'h00, 8'hA5, 4'h0, 0));
    // all four request at once after a reset: order 0,1,2,3
    vecs.push_back(mk(0, 4'b1111, ad2, wd2, 8'h00, 8'h00, 4'h0, 0));
    vecs.push_back(mk(0, 4'b1111, ad2, wd2, 8'h02, 8'h11, 4'h0, 1));
    vecs.push_back(mk(0, 4'b1110, ad2, wd2, 8'h00, 8'h11, 4'h1, 1));
    vecs.push_back(mk(0, 4'b1110, ad2, wd2, 8'h00, 8'h11, 4'h0, 0));
    vecs.push_back(mk(0, 4'b1110, ad2, wd2, 8'h04, 8'h22, 4'h0, 1));
    vecs.push_back(mk(0, 4'b1100, ad2, wd2, 8'h00, 8'h22, 4'h2, 1));
    vecs.push_back(mk(0, 4'b1100, ad2, wd2, 8'h00, 8'h22, 4'h0, 0));
    vecs.push_back(mk(0, 4'b1100, ad2, wd2, 8'h10, 8'h33, 4'h0, 1));
    vecs.push_back(mk(0, 4'b1000, ad2, wd2, 8'h00, 8'h33, 4'h4, 1));
    vecs.push_back(mk(0, 4'b1000, ad2, wd2, 8'h00, 8'h33, 4'h0, 0));
    vecs.push_back(mk(0, 4'b1000, ad2, wd2, 8'h40, 8'h44, 4'h0, 1));
    vecs.push_back(mk(0, 4'b0000, ad2, wd2, 8'h00, 8'h44, 4'h8, 1));
    // requesters 0 and 2 continuously: 0,2,0,2 with ptr wrapping 3->0
    vecs.push_back(mk(0, 4'b0101, ad3, wd3, 8'h00, 8'h44, 4'h0, 0));
    vecs.push_back(mk(0, 4'b0101, ad3, wd3, 8'h20, 8'h5A, 4'h0, 1));
    vecs.push_back(mk(0, 4'b0100, ad3, wd3, 8'h00, 8'h5A, 4'h1, 1));
    vecs.push_back(mk(0, 4'b0101, ad3, wd3, 8'h00, 8'h5A, 4'h0, 0));
    vecs.push_back(mk(0, 4'b0101, ad3, wd3, 8'h08, 8'hC3, 4'h0, 1));
    vecs.push_back(mk(0, 4'b0001, ad3, wd3, 8'h00, 8'hC3, 4'h4, 1));
    vecs.push_back(mk(0, 4'b0101, ad3, wd3, 8'h00, 8'hC3, 4'h0, 0));
    vecs.push_back(mk(0, 4'b0101, ad3, wd3, 8'h20, 8'h5A, 4'h0, 1));
    vecs.push_back(mk(0, 4'b0100, ad3, wd3, 8'h00, 8'h5A, 4'h1, 1));
    vecs.push_back(mk(0, 4'b0101, ad3, wd3, 8'h00, 8'h5A, 4'h0, 0));
    vecs.push_back(mk(0, 4'b0101, ad3, wd3, 8'h08, 8'hC3, 4'h0, 1));
    vecs.push_back(mk(0, 4'b0000, ad3, wd3, 8'h00, 8'hC3, 4'h4, 1));
    // req[3] rises during the ACK of requester 0
    vecs.push_back(mk(0, 4'b0001, ad4, wd4, 8'h00, 8'hC3, 4'h0, 0));
    vecs.push_back(mk(0, 4'b0001, ad4, wd4, 8'h04, 8'h77, 4'h0, 1));
    vecs.push_back(mk(0, 4'b1000, ad4, wd4, 8'h00, 8'h77, 4'h1, 1));
    vecs.push_back(mk(0, 4'b1000, ad4, wd4, 8'h00, 8'h77, 4'h0, 0));
    vecs.push_back(mk(0, 4'b1000, ad4, wd4, 8'h02, 8'h99, 4'h0, 1));
    vecs.push_back(mk(0, 4'b0000, ad4, wd4, 8'h00, 8'h99, 4'h8, 1));
    // one grant to requester 1 so ptr is left at 2
    vecs.push_back(mk(0, 4'b0010, ad4, wd4, 8'h00, 8'h99, 4'h0, 0));
    vecs.push_back(mk(0, 4'b0010, ad4, wd4, 8'h20, 8'hE1, 4'h0, 1));
    vecs.push_back(mk(0, 4'b0000, ad4, wd4, 8'h00, 8'hE1, 4'h2, 1));
    vecs.push_back(mk(0, 4'b0000, ad4, wd4, 8'h00, 8'hE1, 4'h0, 0));

    rst = 1'b1; req = '0; addr = '0; wdata = '0;
    req2 = '0; addr2 = '0; wdata2 = '0;
    repeat (2) @(negedge clk);
    chk("reset reg_en", 32'(reg_en), 32'h0);
    chk("reset reg_din", 32'(reg_din), 32'h0);
    chk("reset gnt", 32'(gnt), 32'h0);
    chk("reset err", 32'(err), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset busy6", 32'(busy2), 32'h0);
    rst = 1'b0;

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      chk($sformatf("row%0d reg_en", k), 32'(reg_en), 32'(vecs[k].en));
      chk($sformatf("row%0d reg_din", k), 32'(reg_din), 32'(vecs[k].din));
      chk($sformatf("row%0d gnt", k), 32'(gnt), 32'(vecs[k].gnt));
      chk($sformatf("row%0d err", k), 32'(err), 32'h0);
      chk($sformatf("row%0d busy", k), 32'(busy), 32'(vecs[k].busy));
      rst   = vecs[k].rst;
      req   = vecs[k].req;
      addr  = vecs[k].addr;
      wdata = vecs[k].wdata;
    end

    // reset during WRITE, with ptr at 2 beforehand
    @(negedge clk);
    req = 4'b0101;
    @(negedge clk);
    chk("midrst write reg_en", 32'(reg_en), 32'h08);
    chk("midrst write reg_din", 32'(reg_din), 32'hC3);
    #2 rst = 1'b1;
    #1;
    chk("midrst same-cycle reg_en", 32'(reg_en), 32'h0);
    chk("midrst same-cycle busy", 32'(busy), 32'h0);
    chk("midrst same-cycle reg_din", 32'(reg_din), 32'h0);
    @(negedge clk);
    chk("midrst no gnt", 32'(gnt), 32'h0);
    chk("midrst idle", 32'(busy), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("postrst ptr0 reg_en", 32'(reg_en), 32'h04);
    chk("postrst ptr0 reg_din", 32'(reg_din), 32'h77);
    @(negedge clk);
    chk("postrst gnt0", 32'(gnt), 32'h1);
    req = 4'b0100;
    @(negedge clk);
    chk("postrst idle", 32'(busy), 32'h0);
    @(negedge clk);
    chk("postrst retry reg_en", 32'(reg_en), 32'h08);
    chk("postrst retry reg_din", 32'(reg_din), 32'hC3);
    @(negedge clk);
    chk("postrst retry gnt", 32'(gnt), 32'h4);
    req = 4'b0000;

    // NREG = 6 instance: out-of-range and in-range addresses on requester 1
    bad_addrs = '{7, 5, 6};
    for (int t = 0; t < 3; t++) begin
      a       = bad_addrs[t];
      exp_en  = (a < 6) ? 6'(1 << a) : 6'b0;
      exp_err = (a >= 6);
      @(negedge clk);
      req2   = 4'b0010;
      addr2  = {3'd0, 3'd0, 3'(a), 3'd0};
      wdata2 = {16'h0, 8'(8'h30 + a), 8'h00};
      @(negedge clk);
      chk($sformatf("n6 a%0d reg_en", a), 32'(reg_en2), 32'(exp_en));
      chk($sformatf("n6 a%0d reg_din", a), 32'(reg_din2), 32'(8'h30 + a));
      chk($sformatf("n6 a%0d write err", a), 32'(err2), 32'h0);
      chk($sformatf("n6 a%0d write busy", a), 32'(busy2), 32'h1);
      @(negedge clk);
      chk($sformatf("n6 a%0d gnt", a), 32'(gnt2), 32'h2);
      chk($sformatf("n6 a%0d err", a), 32'(err2), 32'(exp_err));
      req2 = 4'b0000;
      @(negedge clk);
      chk($sformatf("n6 a%0d err after", a), 32'(err2), 32'h0);
      chk($sformatf("n6 a%0d gnt after", a), 32'(gnt2), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
